// File: rtl/lamp_pwm_sequencer_pkg.sv
// rtl/lamp_pwm_sequencer_pkg.sv - shared types and duty/phase helpers for the lamp PWM sequencer
//
// Package lamp_pkg
//   lamp_mode_e  : per-channel lamp mode encoding (OFF, ON, BREATH, BLINK)
//   cmd_state_e  : command path state (idle / one command pending)
//   lamp_phase() : envelope phase, env + 2*level, modulo 2^(bits+1)
//   lamp_duty()  : duty value for a mode/level at a given envelope position
package lamp_pkg;

  localparam int LAMP_CHAN_W = 3;

  typedef enum logic [1:0] {
    LAMP_OFF    = 2'd0,
    LAMP_ON     = 2'd1,
    LAMP_BREATH = 2'd2,
    LAMP_BLINK  = 2'd3
  } lamp_mode_e;

  typedef enum logic {
    CMD_IDLE = 1'b0,
    CMD_PEND = 1'b1
  } cmd_state_e;

  // Arithmetic is done at 32 bits so one function serves every PWM_BITS;
  // callers truncate the result to their own duty width.
  function automatic logic [31:0] lamp_phase(input logic [31:0] env,
                                             input logic [31:0] level,
                                             input int          bits);
    logic [31:0] mask;
    mask = (32'd1 << (bits + 1)) - 32'd1;
    return (env + (level << 1)) & mask;
  endfunction

  function automatic logic [31:0] lamp_duty(input lamp_mode_e  mode,
                                            input logic [31:0] level,
                                            input logic [31:0] env,
                                            input int          bits);
    logic [31:0] max_v;
    logic [31:0] p;
    logic [31:0] low;
    logic        hi;
    logic [31:0] res;
    max_v = (32'd1 << bits) - 32'd1;
    p     = lamp_phase(env, level, bits);
    low   = p & max_v;
    // Upper half of the phase runs the triangle downwards.
    hi    = ((p >> bits) & 32'd1) != 32'd0;
    res   = 32'd0;
    case (mode)
      LAMP_OFF:    res = 32'd0;
      LAMP_ON:     res = level & max_v;
      LAMP_BREATH: res = hi ? (~low & max_v) : low;
      LAMP_BLINK:  res = hi ? 32'd0 : max_v;
      default:     res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lamp_pwm_sequencer_if.sv
// rtl/lamp_pwm_sequencer_if.sv - valid/ready command port of the lamp PWM sequencer
//
// Interface lamp_cmd_if #(PWM_BITS)
//   cmd_valid   : command offered (master -> slave)
//   cmd_ready   : command can be accepted (slave -> master)
//   cmd_channel : target channel index
//   cmd_mode    : lamp mode
//   cmd_level   : duty (ON) or phase offset (BREATH/BLINK)
import lamp_pkg::*;

interface lamp_cmd_if #(
  parameter int PWM_BITS = 8
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [LAMP_CHAN_W-1:0] cmd_channel;
  lamp_mode_e             cmd_mode;
  logic [PWM_BITS-1:0]    cmd_level;

  modport master (
    output cmd_valid,
    output cmd_channel,
    output cmd_mode,
    output cmd_level,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_channel,
    input  cmd_mode,
    input  cmd_level,
    output cmd_ready
  );
endinterface

// File: rtl/lamp_pwm_channel.sv
// rtl/lamp_pwm_channel.sv - one LED channel: mode/level/duty registers and PWM compare
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   period_end : last tick of the PWM period; only moment settings change
//   env_next   : envelope value being written this cycle
//   pwm_cnt    : shared PWM counter
//   load       : a pending command targets this channel
//   ld_mode    : pending mode
//   ld_level   : pending level
//   led        : registered PWM output, active high
module lamp_pwm_channel
  import lamp_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int IDX      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                period_end,
  input  logic [PWM_BITS:0]   env_next,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                load,
  input  lamp_mode_e          ld_mode,
  input  logic [PWM_BITS-1:0] ld_level,
  output logic                led
);

  // Odd channels start half a triangle away so they breathe in antiphase.
  localparam logic [PWM_BITS-1:0] RST_LEVEL =
    (IDX % 2 == 1) ? {1'b1, {(PWM_BITS-1){1'b0}}} : {PWM_BITS{1'b0}};

  lamp_mode_e          mode_q;
  lamp_mode_e          mode_n;
  logic [PWM_BITS-1:0] level_q;
  logic [PWM_BITS-1:0] level_n;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_n;

  // Duty is computed from the values being written, so a command applied
  // at this boundary is already reflected in the next period.
  always_comb begin
    mode_n  = mode_q;
    level_n = level_q;
    if (load) begin
      mode_n  = ld_mode;
      level_n = ld_level;
    end
    duty_n = PWM_BITS'(lamp_duty(mode_n, 32'(level_n), 32'(env_next), PWM_BITS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= LAMP_BREATH;
      level_q <= RST_LEVEL;
      duty_q  <= '0;
      led     <= 1'b0;
    end else begin
      if (period_end) begin
        mode_q  <= mode_n;
        level_q <= level_n;
        duty_q  <= duty_n;
      end
      led <= (pwm_cnt < duty_q);
    end
  end

endmodule

// File: rtl/lamp_pwm_sequencer.sv
// rtl/lamp_pwm_sequencer.sv - multi-channel LED PWM driver with breathing envelope
//
// Ports
//   CLOCK_50   : system clock
//   RESET_n    : asynchronous active-low reset
//   cmd        : valid/ready command port (lamp_cmd_if.slave)
//   period_end : one-cycle pulse on the last tick of each PWM period
//   LED        : registered PWM outputs, active high
module lamp_pwm_sequencer
  import lamp_pkg::*;
#(
  parameter int CHANNELS         = 5,
  parameter int PWM_BITS         = 8,
  parameter int TICK_DIV         = 1,
  parameter int ENV_STEP_PERIODS = 4
) (
  input  logic                CLOCK_50,
  input  logic                RESET_n,
  lamp_cmd_if.slave           cmd,
  output logic                period_end,
  output logic [CHANNELS-1:0] LED
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PER_W   = (ENV_STEP_PERIODS > 1) ? $clog2(ENV_STEP_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [PRESC_W-1:0]  presc;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PER_W-1:0]    per_cnt;
  logic [PWM_BITS:0]   env;
  logic [PWM_BITS:0]   env_next;
  logic                env_step;

  cmd_state_e             state;
  cmd_state_e             state_n;
  logic                   accept;
  logic                   chan_ok;
  logic [LAMP_CHAN_W-1:0] pend_ch;
  lamp_mode_e             pend_mode;
  logic [PWM_BITS-1:0]    pend_level;

  assign tick       = (presc == PRESC_W'(TICK_DIV - 1));
  assign period_end = tick && (pwm_cnt == PWM_MAX);
  assign env_step   = period_end && (per_cnt == PER_W'(ENV_STEP_PERIODS - 1));
  assign env_next   = env_step ? env + (PWM_BITS+1)'(1) : env;

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
      per_cnt <= '0;
      env     <= '0;
    end else begin
      presc <= tick ? '0 : presc + PRESC_W'(1);
      if (tick) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
      if (period_end) begin
        per_cnt <= (per_cnt == PER_W'(ENV_STEP_PERIODS - 1)) ? '0 : per_cnt + PER_W'(1);
      end
      env <= env_next;
    end
  end

  // Ready comes straight from the state register so the handshake never
  // loops back through the acceptance decode.
  assign cmd.cmd_ready = (state == CMD_IDLE);
  assign accept        = cmd.cmd_valid && (state == CMD_IDLE);
  assign chan_ok       = int'(cmd.cmd_channel) < CHANNELS;

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= CMD_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A command accepted during period_end is idle-state acceptance, so it is
  // latched now and only applied at the next boundary.
  always_comb begin
    state_n = state;
    case (state)
      CMD_IDLE: if (accept && chan_ok) state_n = CMD_PEND;
      CMD_PEND: if (period_end)        state_n = CMD_IDLE;
      default:                         state_n = CMD_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      pend_ch    <= '0;
      pend_mode  <= LAMP_OFF;
      pend_level <= '0;
    end else if (accept && chan_ok) begin
      pend_ch    <= cmd.cmd_channel;
      pend_mode  <= cmd.cmd_mode;
      pend_level <= cmd.cmd_level;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    lamp_pwm_channel #(
      .PWM_BITS (PWM_BITS),
      .IDX      (gi)
    ) u_ch (
      .clk        (CLOCK_50),
      .rst_n      (RESET_n),
      .period_end (period_end),
      .env_next   (env_next),
      .pwm_cnt    (pwm_cnt),
      .load       ((state == CMD_PEND) && (pend_ch == LAMP_CHAN_W'(gi))),
      .ld_mode    (pend_mode),
      .ld_level   (pend_level),
      .led        (LED[gi])
    );
  end

endmodule

// File: doc/lamp_pwm_sequencer.md
# lamp_pwm_sequencer

Multi-channel LED PWM driver for the evaluation-board top level. It sits between the board LED pins and the system logic. It generates one shared PWM counter and one shared triangular breathing envelope. Each channel receives a duty value from its own mode/level setting, loaded through a valid/ready command port. Settings change only at PWM period boundaries, so the LEDs never glitch.

## Interface
- `CHANNELS`, 5: number of LED outputs (1..8).
- `PWM_BITS`, 8: PWM counter and duty width; MAX = 2^PWM_BITS-1.
- `TICK_DIV`, 1: clocks per PWM count step (≥1).
- `ENV_STEP_PERIODS`, 4: PWM periods per envelope step (≥1).

Ports:
- `CLOCK_50`  in  1  system clock, single clock domain.
- `RESET_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command can be accepted.
- `cmd_channel`  in  3  target channel index.
- `cmd_mode`  in  2  0=OFF, 1=ON, 2=BREATH, 3=BLINK.
- `cmd_level`  in  PWM_BITS  duty (ON) or phase offset (BREATH/BLINK).
- `period_end`  out  1  one-cycle pulse on the last tick of each PWM period.
- `LED`  out  CHANNELS  registered PWM outputs, active high.

## Operation
- Prescaler `presc` counts 0..TICK_DIV-1. `tick` = (presc==TICK_DIV-1).
- On `tick`, `pwm_cnt` increments and wraps MAX→0. `period_end` = tick && pwm_cnt==MAX (combinational from registers).
- On `period_end`:
  - `per_cnt` increments mod ENV_STEP_PERIODS.
  - When per_cnt==ENV_STEP_PERIODS-1, `env` (PWM_BITS+1 bits) increments mod 2^(PWM_BITS+1).
- Phase `p` = env' + {level',1'b0}, mod 2^(PWM_BITS+1).
- Duty per mode:
  - OFF: 0.
  - ON: level'.
  - BREATH: p[MSB] ? ~p[PWM_BITS-1:0] : p[PWM_BITS-1:0].
  - BLINK: p[MSB] ? 0 : MAX.
- Primes denote values being written in the same `period_end` cycle, including a pending command. All duty registers load on `period_end` only.
- Every clock, `LED[i] <= (pwm_cnt < duty_i)`. Duty 0 means the LED is never on. Duty MAX means it is on MAX of 2^PWM_BITS counts.
- Command handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - If cmd_channel < CHANNELS, the command is latched as pending and `cmd_ready` drops the next cycle. It is applied on the next `period_end`, and `cmd_ready` rises the cycle after that.
  - If cmd_channel ≥ CHANNELS, the command is accepted and discarded. `cmd_ready` stays high.
- Acceptance in the same cycle as `period_end`: the command is latched as pending. It applies at the following `period_end`, not the current one.
- Only one command is pending at a time. A later command to the same channel overwrites the earlier one, with the last applied winning.

## Timing
- Reset values:
  - presc, pwm_cnt, per_cnt, env, all duty registers: 0.
  - LED: 0.
  - cmd_ready: 1.
  - period_end: 0.
  - Pending: empty.
  - Channel i mode: BREATH. Level: 0 for even i, 2^(PWM_BITS-1) for odd i, so odd channels breathe in antiphase.
- Asserting RESET_n low mid-period forces LED to 0 asynchronously and drops any pending command.
- Latency from command acceptance to LED effect: at most one full PWM period plus 1 clock. The new duty compares against pwm_cnt=0 in the cycle after `period_end`.
- LED lags `pwm_cnt` by one clock.
- PWM period = TICK_DIV·2^PWM_BITS clocks. Envelope full cycle = 2^(PWM_BITS+1)·ENV_STEP_PERIODS periods.

## Structure
- Package `lamp_pkg`:
  - Mode encodings: LAMP_OFF, LAMP_ON, LAMP_BREATH, LAMP_BLINK.
  - Duty/phase function shared by RTL and bench model.
- Sub-module `lamp_pwm_channel`, instanced CHANNELS times. It holds the mode/level/duty registers, the duty function and the compare flop for `LED[i]`.
- Top of the block holds the prescaler, pwm_cnt, per_cnt, env and the command/pending logic.

## Test plan
1. Reset, defaults: `LED`=0 and `cmd_ready`=1 during reset. In the first period all LEDs stay 0. With ENV_STEP_PERIODS=1 at period 129, even and odd channels have duties 128 and 127.
2. ON ch2 level 64, TICK_DIV=1: `cmd_ready` is low from the next cycle until the cycle after `period_end`. Afterwards LED[2] is high for exactly 64 of every 256 clocks, starting at pwm_cnt=0.
3. ON level 0 → LED never high. ON level 255 → high 255/256 clocks. ON level 128 with TICK_DIV=3 → high for 384 of every 768 clocks.
4. BREATH ch0 level 0, ENV_STEP_PERIODS=1: duty over successive periods is 0,1,…,255,255,254,…,0, repeating every 512 periods.
5. Command with cmd_channel=7 (CHANNELS=5): accepted, `cmd_ready` stays high, no LED change. A command accepted in the `period_end` cycle takes effect one period later.
6. RESET_n low mid-period with a command pending and LED high → LED 0 within the same cycle. After release, the pending command is discarded and the defaults resume.
